// File: rtl/MD_pkg.sv
// Shared cell-grid constants and the state encoding of the cell scan sequencer.
package MD_pkg;

    localparam int CELL_ID_WIDTH = 4;
    localparam int X_DIM         = 2;
    localparam int Y_DIM         = 2;
    localparam int Z_DIM         = 2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        EMIT = 3'd3,
        DONE = 3'd4
    } cell_scan_state_t;

    function automatic logic [3*CELL_ID_WIDTH-1:0] pack_cid(
        input logic [CELL_ID_WIDTH-1:0] x,
        input logic [CELL_ID_WIDTH-1:0] y,
        input logic [CELL_ID_WIDTH-1:0] z
    );
        return {z, y, x};
    endfunction

endpackage

// File: rtl/cell_idx_counter_3d.sv
// x-fastest wrapping x/y/z cell index counter; reports the packed {z,y,x} cell
// ID and whether the current cell is the last one of the node.
module cell_idx_counter_3d
    import MD_pkg::*;
#(
    parameter int X_DIM = MD_pkg::X_DIM,
    parameter int Y_DIM = MD_pkg::Y_DIM,
    parameter int Z_DIM = MD_pkg::Z_DIM
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_clr,
    input  logic                         i_inc,
    output logic [3*CELL_ID_WIDTH-1:0]   o_cid,
    output logic                         o_is_final
);

    localparam logic [CELL_ID_WIDTH-1:0] IDX_ZERO = {CELL_ID_WIDTH{1'b0}};
    localparam logic [CELL_ID_WIDTH-1:0] IDX_ONE  = {{(CELL_ID_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CELL_ID_WIDTH-1:0] X_LAST   = CELL_ID_WIDTH'(X_DIM - 1);
    localparam logic [CELL_ID_WIDTH-1:0] Y_LAST   = CELL_ID_WIDTH'(Y_DIM - 1);
    localparam logic [CELL_ID_WIDTH-1:0] Z_LAST   = CELL_ID_WIDTH'(Z_DIM - 1);

    logic [CELL_ID_WIDTH-1:0] x_r;
    logic [CELL_ID_WIDTH-1:0] y_r;
    logic [CELL_ID_WIDTH-1:0] z_r;
    logic                     x_wrap_s;
    logic                     y_wrap_s;
    logic                     z_wrap_s;

    assign x_wrap_s   = (x_r == X_LAST);
    assign y_wrap_s   = (y_r == Y_LAST);
    assign z_wrap_s   = (z_r == Z_LAST);
    assign o_cid      = pack_cid(x_r, y_r, z_r);
    assign o_is_final = x_wrap_s & y_wrap_s & z_wrap_s;

    // Clear has priority; an increment carries x into y and y into z.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_r <= IDX_ZERO;
            y_r <= IDX_ZERO;
            z_r <= IDX_ZERO;
        end else if (i_clr) begin
            x_r <= IDX_ZERO;
            y_r <= IDX_ZERO;
            z_r <= IDX_ZERO;
        end else if (i_inc) begin
            if (x_wrap_s) begin
                x_r <= IDX_ZERO;
                if (y_wrap_s) begin
                    y_r <= IDX_ZERO;
                    z_r <= z_wrap_s ? IDX_ZERO : (z_r + IDX_ONE);
                end else begin
                    y_r <= y_r + IDX_ONE;
                end
            end else begin
                x_r <= x_r + IDX_ONE;
            end
        end
    end

endmodule

// File: rtl/cell_scan_seq.sv
// Walks every local cell, fetches its particle count and streams one record per
// particle. Optional macro CELL_SCAN_EMIT_EMPTY_EN emits one marker record per empty cell.
module cell_scan_seq
    import MD_pkg::*;
#(
    parameter int X_DIM             = MD_pkg::X_DIM,
    parameter int Y_DIM             = MD_pkg::Y_DIM,
    parameter int Z_DIM             = MD_pkg::Z_DIM,
    parameter int PARTICLE_ID_WIDTH = 7
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           i_start,
    output logic                           o_busy,
    output logic                           o_done,
    output logic                           o_cnt_rd_en,
    output logic [3*CELL_ID_WIDTH-1:0]     o_cnt_cid,
    input  logic [PARTICLE_ID_WIDTH:0]     i_cnt,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [3*CELL_ID_WIDTH-1:0]     o_cid,
    output logic [PARTICLE_ID_WIDTH-1:0]   o_particle_id,
    output logic                           o_last_in_cell,
`ifdef CELL_SCAN_EMIT_EMPTY_EN
    output logic                           o_last,
    output logic                           o_empty
`else
    output logic                           o_last
`endif
);

    localparam logic [PARTICLE_ID_WIDTH:0]   CNT_ZERO = {(PARTICLE_ID_WIDTH+1){1'b0}};
    localparam logic [PARTICLE_ID_WIDTH:0]   CNT_ONE  = {{PARTICLE_ID_WIDTH{1'b0}}, 1'b1};
    localparam logic [PARTICLE_ID_WIDTH:0]   CNT_MAX  = {1'b1, {PARTICLE_ID_WIDTH{1'b0}}};
    localparam logic [PARTICLE_ID_WIDTH-1:0] PID_ZERO = {PARTICLE_ID_WIDTH{1'b0}};
    localparam logic [PARTICLE_ID_WIDTH-1:0] PID_ONE  = {{(PARTICLE_ID_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [3*CELL_ID_WIDTH-1:0]   CID_ZERO = {(3*CELL_ID_WIDTH){1'b0}};

    cell_scan_state_t               state_r;
    logic [PARTICLE_ID_WIDTH:0]     cnt_r;
    logic [PARTICLE_ID_WIDTH:0]     cnt_clamped_s;
    logic [PARTICLE_ID_WIDTH-1:0]   pid_inc_s;
    logic                           last_next_s;
    logic                           is_final_s;
    logic                           clr_s;
    logic                           inc_s;

    // The count memory address is the index counter itself, so it is already registered.
    cell_idx_counter_3d #(
        .X_DIM (X_DIM),
        .Y_DIM (Y_DIM),
        .Z_DIM (Z_DIM)
    ) u_idx (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clr      (clr_s),
        .i_inc      (inc_s),
        .o_cid      (o_cnt_cid),
        .o_is_final (is_final_s)
    );

    // Counts beyond 2^PARTICLE_ID_WIDTH saturate so the particle index never wraps.
    always_comb begin
        if (i_cnt > CNT_MAX) begin
            cnt_clamped_s = CNT_MAX;
        end else begin
            cnt_clamped_s = i_cnt;
        end
    end

    assign pid_inc_s   = o_particle_id + PID_ONE;
    assign last_next_s = ({1'b0, pid_inc_s} == (cnt_r - CNT_ONE));

    // Index counter control: clear on accepted start, step when leaving a non-final cell.
    always_comb begin
        clr_s = 1'b0;
        inc_s = 1'b0;
        case (state_r)
            IDLE: begin
                clr_s = i_start;
            end
            WAIT: begin
`ifdef CELL_SCAN_EMIT_EMPTY_EN
                inc_s = 1'b0;
`else
                if ((cnt_clamped_s == CNT_ZERO) && !is_final_s) begin
                    inc_s = 1'b1;
                end else begin
                    inc_s = 1'b0;
                end
`endif
            end
            EMIT: begin
                if (i_ready && o_last_in_cell && !is_final_s) begin
                    inc_s = 1'b1;
                end else begin
                    inc_s = 1'b0;
                end
            end
            default: begin
                clr_s = 1'b0;
                inc_s = 1'b0;
            end
        endcase
    end

    // Scan FSM with all handshake, payload and status outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r        <= IDLE;
            cnt_r          <= CNT_ZERO;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_cnt_rd_en    <= 1'b0;
            o_valid        <= 1'b0;
            o_cid          <= CID_ZERO;
            o_particle_id  <= PID_ZERO;
            o_last_in_cell <= 1'b0;
            o_last         <= 1'b0;
`ifdef CELL_SCAN_EMIT_EMPTY_EN
            o_empty        <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    o_done <= 1'b0;
                    if (i_start) begin
                        state_r     <= REQ;
                        o_busy      <= 1'b1;
                        o_cnt_rd_en <= 1'b1;
                    end
                end
                REQ: begin
                    o_cnt_rd_en <= 1'b0;
                    state_r     <= WAIT;
                end
                WAIT: begin
                    cnt_r <= cnt_clamped_s;
                    if (cnt_clamped_s != CNT_ZERO) begin
                        state_r        <= EMIT;
                        o_valid        <= 1'b1;
                        o_cid          <= o_cnt_cid;
                        o_particle_id  <= PID_ZERO;
                        o_last_in_cell <= (cnt_clamped_s == CNT_ONE);
                        o_last         <= (cnt_clamped_s == CNT_ONE) & is_final_s;
`ifdef CELL_SCAN_EMIT_EMPTY_EN
                        o_empty        <= 1'b0;
`endif
                    end else begin
`ifdef CELL_SCAN_EMIT_EMPTY_EN
                        // Empty cell still produces a single marker record.
                        state_r        <= EMIT;
                        o_valid        <= 1'b1;
                        o_cid          <= o_cnt_cid;
                        o_particle_id  <= PID_ZERO;
                        o_last_in_cell <= 1'b1;
                        o_last         <= is_final_s;
                        o_empty        <= 1'b1;
`else
                        if (is_final_s) begin
                            state_r <= DONE;
                            o_done  <= 1'b1;
                            o_busy  <= 1'b0;
                        end else begin
                            state_r     <= REQ;
                            o_cnt_rd_en <= 1'b1;
                        end
`endif
                    end
                end
                EMIT: begin
                    if (i_ready) begin
                        if (o_last_in_cell) begin
                            o_valid        <= 1'b0;
                            o_last_in_cell <= 1'b0;
                            o_last         <= 1'b0;
                            if (is_final_s) begin
                                state_r <= DONE;
                                o_done  <= 1'b1;
                                o_busy  <= 1'b0;
                            end else begin
                                state_r     <= REQ;
                                o_cnt_rd_en <= 1'b1;
                            end
                        end else begin
                            o_particle_id  <= pid_inc_s;
                            o_last_in_cell <= last_next_s;
                            o_last         <= last_next_s & is_final_s;
                        end
                    end
                end
                DONE: begin
                    o_done  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    state_r     <= IDLE;
                    o_busy      <= 1'b0;
                    o_done      <= 1'b0;
                    o_cnt_rd_en <= 1'b0;
                    o_valid     <= 1'b0;
                end
            endcase
        end
    end

endmodule
